// File: rtl/uart_rx_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_cfg_pkg
// Description : Shared types and constants for the configurable UART receiver
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_cfg_pkg;

   // Receiver FSM state encoding
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   // Prescale used when the requested one is too small to vote on
   localparam int DEFAULT_PRESCALE = 8;
   localparam int MIN_PRESCALE     = 4;

endpackage : uart_rx_cfg_pkg
`default_nettype wire

// File: rtl/uart_data_sampling.sv
`default_nettype none
// ============================================================================
// Module      : uart_data_sampling
// Description : Three-point majority voter around the middle of each bit cell
// Revision    : 1.0 - initial release
// ============================================================================
module uart_data_sampling
   import uart_rx_cfg_pkg::*;
#(
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rx_in,
   input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic                      sampled_bit
);

   localparam logic [PRESCALE_WIDTH-1:0] CNT_ONE = 1;

   logic [PRESCALE_WIDTH-1:0] mid;
   logic                      s_early;
   logic                      s_mid;
   logic                      vote;

   assign mid  = prescale >> 1;
   // The third sample is the live line, so the vote lands in the register on
   // the M+1 edge and is visible to the FSM from edge_cnt = M+2 onward.
   assign vote = (s_early & s_mid) | (s_early & rx_in) | (s_mid & rx_in);

   // Capture the two early samples and register the 2-of-3 vote
   always_ff @(posedge clk) begin
      if (rst) begin
         s_early     <= 1'b1;
         s_mid       <= 1'b1;
         sampled_bit <= 1'b1;
      end else begin
         if (edge_cnt == mid - CNT_ONE) s_early <= rx_in;
         if (edge_cnt == mid)           s_mid   <= rx_in;
         if (edge_cnt == mid + CNT_ONE) sampled_bit <= vote;
      end
   end

endmodule : uart_data_sampling
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_cfg
// Description : UART receiver with per-frame latched prescale, parity and
//               stop-bit configuration; error and valid pulses are one-hot
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cfg
   import uart_rx_cfg_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rx_in,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic                      par_en,
   input  logic                      par_typ,
   input  logic                      stop2,
   output logic [DATA_WIDTH-1:0]     p_data,
   output logic                      data_valid,
   output logic                      par_err,
   output logic                      stp_err
);

   localparam logic [PRESCALE_WIDTH-1:0] CNT_ONE   = 1;
   localparam logic [PRESCALE_WIDTH-1:0] CNT_TWO   = 2;
   localparam logic [3:0]                BIT_ONE   = 4'd1;
   localparam logic [3:0]                LAST_DATA = 4'(DATA_WIDTH - 1);

   rx_state_t                 state,     state_n;
   logic [PRESCALE_WIDTH-1:0] edge_cnt,  edge_n;
   logic [3:0]                bit_cnt,   bit_n;
   logic [DATA_WIDTH-1:0]     shreg,     sh_n;
   logic [DATA_WIDTH-1:0]     pd_n;
   logic                      dv_n, pe_n, se_n;
   logic                      frame_bad, bad_n;

   // Configuration frozen for the duration of one frame
   logic [PRESCALE_WIDTH-1:0] p_lat,     p_lat_n;
   logic                      par_en_l,  par_en_n;
   logic                      par_typ_l, par_typ_n;
   logic                      stop2_l,   stop2_n;

   logic [PRESCALE_WIDTH-1:0] eff_prescale;
   logic [PRESCALE_WIDTH-1:0] vote_point;
   logic                      bit_end;
   logic                      sampled_bit;
   logic                      begin_frame;
   logic                      stop_bad;
   logic                      last_stop;

   assign eff_prescale = (prescale < PRESCALE_WIDTH'(MIN_PRESCALE))
                         ? PRESCALE_WIDTH'(DEFAULT_PRESCALE) : prescale;
   assign vote_point   = (p_lat >> 1) + CNT_TWO;
   assign bit_end      = (edge_cnt == p_lat - CNT_ONE);

   uart_data_sampling #(
      .PRESCALE_WIDTH (PRESCALE_WIDTH)
   ) u_sampling (
      .clk         (clk),
      .rst         (rst),
      .rx_in       (rx_in),
      .edge_cnt    (edge_cnt),
      .prescale    (p_lat),
      .sampled_bit (sampled_bit)
   );

   // State, counters, datapath and output pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         edge_cnt   <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         p_data     <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         frame_bad  <= 1'b0;
         p_lat      <= '0;
         par_en_l   <= 1'b0;
         par_typ_l  <= 1'b0;
         stop2_l    <= 1'b0;
      end else begin
         state      <= state_n;
         edge_cnt   <= edge_n;
         bit_cnt    <= bit_n;
         shreg      <= sh_n;
         p_data     <= pd_n;
         data_valid <= dv_n;
         par_err    <= pe_n;
         stp_err    <= se_n;
         frame_bad  <= bad_n;
         p_lat      <= p_lat_n;
         par_en_l   <= par_en_n;
         par_typ_l  <= par_typ_n;
         stop2_l    <= stop2_n;
      end
   end

   // Next-state, counter and pulse decisions
   always_comb begin
      state_n     = state;
      edge_n      = edge_cnt;
      bit_n       = bit_cnt;
      sh_n        = shreg;
      pd_n        = p_data;
      dv_n        = 1'b0;
      pe_n        = 1'b0;
      se_n        = 1'b0;
      bad_n       = frame_bad;
      p_lat_n     = p_lat;
      par_en_n    = par_en_l;
      par_typ_n   = par_typ_l;
      stop2_n     = stop2_l;
      begin_frame = 1'b0;
      stop_bad    = 1'b0;
      last_stop   = 1'b0;

      if (state != IDLE) begin
         edge_n = bit_end ? '0 : edge_cnt + CNT_ONE;
      end

      case (state)
         IDLE: begin
            if (!rx_in) begin
               begin_frame = 1'b1;
            end
         end
         START: begin
            // A start bit that votes high was only a glitch
            if ((edge_cnt == vote_point) && sampled_bit) begin
               state_n = IDLE;
               edge_n  = '0;
            end else if (bit_end) begin
               state_n = sampled_bit ? IDLE : DATA;
               bit_n   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               sh_n = {sampled_bit, shreg[DATA_WIDTH-1:1]};
               if (bit_cnt == LAST_DATA) begin
                  bit_n   = '0;
                  state_n = par_en_l ? PARITY : STOP;
               end else begin
                  bit_n = bit_cnt + BIT_ONE;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               if (sampled_bit != ((^shreg) ^ par_typ_l)) begin
                  pe_n  = 1'b1;
                  bad_n = 1'b1;
               end
               bit_n   = '0;
               state_n = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               stop_bad  = !sampled_bit;
               se_n      = stop_bad;
               last_stop = !stop2_l || (bit_cnt == BIT_ONE);
               if (!last_stop) begin
                  bit_n = BIT_ONE;
                  bad_n = frame_bad | stop_bad;
               end else begin
                  if (!(frame_bad || stop_bad)) begin
                     pd_n = shreg;
                     dv_n = 1'b1;
                  end
                  // A low line here is already the next start bit
                  if (!rx_in) begin
                     begin_frame = 1'b1;
                  end else begin
                     state_n = IDLE;
                     bad_n   = 1'b0;
                  end
               end
            end
         end
         default: begin
            state_n = IDLE;
            edge_n  = '0;
         end
      endcase

      if (begin_frame) begin
         state_n   = START;
         edge_n    = '0;
         bit_n     = '0;
         bad_n     = 1'b0;
         p_lat_n   = eff_prescale;
         par_en_n  = par_en;
         par_typ_n = par_typ;
         stop2_n   = stop2;
      end
   end

endmodule : uart_rx_cfg
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_cfg
// Description : Directed self-checking bench for uart_rx_cfg
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_in;
   logic [5:0] prescale;
   logic       par_en;
   logic       par_typ;
   logic       stop2;
   logic [7:0] p_data;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;

   int checks = 0;
   int errors = 0;

   int cyc         = 0;
   int dv_cnt      = 0;
   int pe_cnt      = 0;
   int se_cnt      = 0;
   int multi_cnt   = 0;
   int dv_last_cyc = 0;
   int dv_prev_cyc = 0;
   logic [7:0] dv_last_data = 8'h00;
   logic [7:0] dv_prev_data = 8'h00;

   int dv0, pe0, se0;
   logic [31:0] v2;

   uart_rx_cfg #(
      .DATA_WIDTH     (8),
      .PRESCALE_WIDTH (6)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_in      (rx_in),
      .prescale   (prescale),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .stop2      (stop2),
      .p_data     (p_data),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stp_err    (stp_err)
   );

   always #5 clk = ~clk;

   // Pulse monitor, sampled on the inactive edge
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (data_valid) begin
         dv_cnt       <= dv_cnt + 1;
         dv_last_cyc  <= cyc;
         dv_prev_cyc  <= dv_last_cyc;
         dv_last_data <= p_data;
         dv_prev_data <= dv_last_data;
      end
      if (par_err) pe_cnt <= pe_cnt + 1;
      if (stp_err) se_cnt <= se_cnt + 1;
      if ($countones({data_valid, par_err, stp_err}) > 1) multi_cnt <= multi_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bits(input logic [31:0] bits, input int n, input int p);
      for (int i = 0; i < n; i++) begin
         rx_in = bits[i];
         repeat (p) tick();
      end
   endtask

   task automatic send_frame(input logic [7:0] data, input logic use_par, input logic pbit,
                             input logic stop_a, input logic stop_b, input logic two_stop,
                             input int p);
      logic [31:0] v;
      int n;
      v = '0;
      v[0] = 1'b0;
      for (int i = 0; i < 8; i++) v[1+i] = data[i];
      n = 9;
      if (use_par) begin
         v[n] = pbit;
         n++;
      end
      v[n] = stop_a;
      n++;
      if (two_stop) begin
         v[n] = stop_b;
         n++;
      end
      send_bits(v, n, p);
   endtask

   task automatic snap();
      dv0 = dv_cnt;
      pe0 = pe_cnt;
      se0 = se_cnt;
   endtask

   // Directed stimulus sequence
   initial begin
      rst = 1'b1; rx_in = 1'b1; prescale = 6'd8;
      par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
      repeat (3) tick();
      check("rst_p_data", p_data, 8'h00);
      check("rst_dv", data_valid, 1'b0);
      check("rst_pe", par_err, 1'b0);
      check("rst_se", stp_err, 1'b0);
      rst = 1'b0;
      repeat (5) tick();

      // Odd parity, good frame
      par_en = 1'b1; par_typ = 1'b1;
      snap();
      send_frame(8'h9B, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8);
      rx_in = 1'b1; repeat (20) tick();
      check("odd_dv", dv_cnt - dv0, 1);
      check("odd_pe", pe_cnt - pe0, 0);
      check("odd_se", se_cnt - se0, 0);
      check("odd_p_data", p_data, 8'h9B);

      // Even parity, good then bad parity bit
      par_typ = 1'b0;
      snap();
      send_frame(8'h9B, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8);
      rx_in = 1'b1; repeat (20) tick();
      check("even_dv", dv_cnt - dv0, 1);
      check("even_p_data", p_data, 8'h9B);
      snap();
      send_frame(8'h9B, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8);
      rx_in = 1'b1; repeat (20) tick();
      check("perr_pe", pe_cnt - pe0, 1);
      check("perr_dv", dv_cnt - dv0, 0);
      check("perr_p_data", p_data, 8'h9B);

      // Two stop bits at P=16, second one low
      prescale = 6'd16; par_en = 1'b0; stop2 = 1'b1;
      snap();
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16);
      rx_in = 1'b1; repeat (40) tick();
      check("stop_se", se_cnt - se0, 1);
      check("stop_dv", dv_cnt - dv0, 0);
      check("stop_p_data", p_data, 8'h9B);
      snap();
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16);
      rx_in = 1'b1; repeat (40) tick();
      check("stop_next_dv", dv_cnt - dv0, 1);
      check("stop_next_p_data", p_data, 8'h3C);

      // Two-cycle low glitch, then a real frame
      prescale = 6'd8; stop2 = 1'b0;
      snap();
      rx_in = 1'b0; repeat (2) tick();
      rx_in = 1'b1; repeat (20) tick();
      check("glitch_dv", dv_cnt - dv0, 0);
      check("glitch_pe", pe_cnt - pe0, 0);
      check("glitch_se", se_cnt - se0, 0);
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8);
      rx_in = 1'b1; repeat (20) tick();
      check("glitch_next_dv", dv_cnt - dv0, 1);
      check("glitch_next_p_data", p_data, 8'hA5);

      // Back-to-back frames, prescale change inside the second one
      snap();
      send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8);
      v2 = {22'd0, 1'b1, 8'hFE, 1'b0};
      send_bits(v2, 4, 8);
      prescale = 6'd16;
      send_bits(v2 >> 4, 6, 8);
      rx_in = 1'b1; repeat (20) tick();
      prescale = 6'd8;
      check("b2b_dv", dv_cnt - dv0, 2);
      check("b2b_spacing", dv_last_cyc - dv_prev_cyc, 80);
      check("b2b_first", dv_prev_data, 8'h01);
      check("b2b_second", dv_last_data, 8'hFE);

      // Reset inside data bit 4, then a clean frame
      snap();
      v2 = {22'd0, 1'b1, 8'h77, 1'b0};
      send_bits(v2, 5, 8);
      rx_in = v2[5];
      repeat (3) tick();
      rst = 1'b1;
      repeat (2) tick();
      check("mrst_p_data", p_data, 8'h00);
      check("mrst_dv", data_valid, 1'b0);
      check("mrst_pe", par_err, 1'b0);
      check("mrst_se", stp_err, 1'b0);
      rst = 1'b0;
      rx_in = 1'b1; repeat (24) tick();
      check("mrst_no_dv", dv_cnt - dv0, 0);
      check("mrst_no_pe", pe_cnt - pe0, 0);
      check("mrst_no_se", se_cnt - se0, 0);
      send_frame(8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8);
      rx_in = 1'b1; repeat (20) tick();
      check("mrst_next_dv", dv_cnt - dv0, 1);
      check("mrst_next_p_data", p_data, 8'h77);

      check("pulses_one_hot", multi_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_uart_rx_cfg
`default_nettype wire

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: data bits per frame; legal values 5..9.
REQ-002 The block SHALL have parameter PRESCALE_WIDTH, default 6: width of the prescale input.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all logic SHALL be rising-edge clocked.
REQ-004 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have port rx_in, input, 1: serial line, idle high, LSB first.
REQ-006 The block SHALL have port prescale, input, PRESCALE_WIDTH: oversampling ratio, in clk cycles per bit.
REQ-007 The block SHALL have port par_en, input, 1: 1 means a parity bit follows the data bits.
REQ-008 The block SHALL have port par_typ, input, 1: 0 means even parity, 1 means odd parity.
REQ-009 The block SHALL have port stop2, input, 1: 1 means two stop bits, 0 means one stop bit.
REQ-010 The block SHALL have port p_data, output, DATA_WIDTH: last good received word.
REQ-011 The block SHALL have port data_valid, output, 1: one-cycle pulse when a good frame completes.
REQ-012 The block SHALL have port par_err, output, 1: one-cycle pulse when parity mismatches.
REQ-013 The block SHALL have port stp_err, output, 1: one-cycle pulse when a stop bit samples low.

Function
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP.
REQ-015 In IDLE, rx_in==0 SHALL move the FSM to START with edge_cnt=0 and bit_cnt=0.
REQ-016 On the IDLE->START transition, prescale, par_en, par_typ and stop2 SHALL be latched; changes to them mid-frame SHALL be ignored.
REQ-017 A latched prescale below 4 SHALL be treated as 8.
REQ-018 edge_cnt SHALL count 0..P-1 within each bit, where P is the latched prescale; at P-1 it SHALL wrap to 0 and advance the bit.
REQ-019 Each bit SHALL be sampled at edge_cnt = M-1, M and M+1, where M = P>>1.
REQ-020 The bit value SHALL be the 2-of-3 majority of those samples, registered at edge_cnt = M+2.
REQ-021 START: a majority value of 1 (glitch) SHALL return the FSM to IDLE at edge_cnt = M+2, with no output pulses.
REQ-022 START SHALL otherwise go to DATA at the end of the bit.
REQ-023 DATA SHALL shift the majority bit into a DATA_WIDTH shift register, LSB first.
REQ-024 After DATA_WIDTH bits, DATA SHALL go to PARITY if par_en=1, else to STOP.
REQ-025 PARITY SHALL compare the majority bit against XOR(data) XOR par_typ.
REQ-026 A parity mismatch SHALL pulse par_err for one cycle at the end of the parity bit, and the frame SHALL be marked bad.
REQ-027 STOP SHALL check one stop bit, or two if stop2=1; any stop bit with majority 0 SHALL pulse stp_err once at the end of that bit and mark the frame bad.
REQ-028 At the end of the final stop bit of a good frame, the shift register SHALL load into p_data, and data_valid SHALL pulse for exactly one cycle on the next clk.
REQ-029 On a bad frame, p_data SHALL hold its previous value and data_valid SHALL stay 0.
REQ-030 p_data SHALL hold its value until the next good frame.
REQ-031 At the end of the final stop bit, rx_in==0 SHALL go directly to START with edge_cnt=0, so back-to-back frames lose no cycle.
REQ-032 Otherwise the FSM SHALL go to IDLE at the end of the final stop bit.
REQ-033 At most one of data_valid, par_err and stp_err SHALL be asserted in any cycle.

Reset
REQ-034 rst=1 SHALL force IDLE, edge_cnt=0, bit_cnt=0, shift register=0 and the latched configuration to 0 on the next clk edge.
REQ-035 On the same edge, rst=1 SHALL force p_data=0, data_valid=0, par_err=0 and stp_err=0.
REQ-036 A reset mid-frame SHALL discard the frame with no pulses; reception SHALL restart on the first rx_in==0 after rst falls.

Structure
REQ-037 The state encoding and the default prescale (8) SHALL reside in the shared package uart_rx_cfg_pkg.
REQ-038 The 3-sample majority voter SHALL be the sub-module uart_data_sampling (inputs: clk, rst, rx_in, edge_cnt, prescale; output: sampled_bit).
REQ-039 The edge/bit counters and the FSM SHALL live in the top module.

Verification
REQ-040 Odd parity: P=8, DATA_WIDTH=8, par_en=1, par_typ=1, stop2=0, frame 0x9B, parity bit 0 -> p_data=0x9B, data_valid one pulse, no errors.
REQ-041 Even parity: same frame 0x9B with par_typ=0, parity bit 1 -> data_valid, p_data=0x9B; then parity bit 0 -> par_err one pulse, no data_valid, p_data still 0x9B.
REQ-042 Stop error: P=16, par_en=0, stop2=1, data 0x5A, second stop bit driven 0 -> stp_err one pulse, no data_valid; the next good frame 0x3C is received.
REQ-043 Glitch: rx_in low for 2 cycles at P=8 -> FSM returns to IDLE, no pulses; the following valid frame 0xA5 is received.
REQ-044 Back-to-back and config change: frames 0x01 and 0xFE with no idle gap at P=8; prescale changed to 16 mid-frame -> both frames received at P=8, two data_valid pulses P*10 cycles apart.
REQ-045 Reset mid-frame: assert rst in bit 4 of a frame -> all outputs 0, no pulses; the next full frame 0x77 is received correctly.
